conv_mac_pool: RTL
==================

# conv_mac_pool

Multiplier/accumulator pool at the receiving end of the convolution controller's dispatch interface. Accepts image windows and filter slices into free lanes, computes one F×F×K dot product per lane, and publishes a lane-occupancy map back to the controller. Signals partial/full convolution completion and streams results with their output index to the writeback stage.

## Interface
- NLANE, 8, number of MAC lanes
- LANE_BITS, 3, lane select width (log2 NLANE)
- F, 3, filter height/width
- K, 3, channel count
- W, 24, signed data width of pixels and weights
- ACC_W, 56, signed accumulator/result width (≥ 2W+ceil(log2(F·F·K)))
- IDX_W, 24, output-position index width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- disp_valid  in  1  dispatch request
- disp_ready  out  1  selected lane free (= !busy_map[disp_lane])
- disp_lane  in  LANE_BITS  target lane
- disp_index  in  IDX_W  output-position tag, echoed with result
- disp_last  in  1  dispatch is the final one of the convolution
- disp_win  in  F·F·K·W  window, element (k,r,c) at bits [((k·F+r)·F+c)·W +: W]
- disp_flt  in  F·F·K·W  filter slice, same packing
- mult_en  in  1  pool-wide compute enable; lanes stall when 0
- busy_map  out  NLANE  1 = lane occupied (MAC or HOLD)
- done_partial  out  1  one-cycle pulse: pool drained, no last pending
- done_full  out  1  sticky: pool drained after a last-tagged dispatch
- clear  in  1  clears done_full
- res_valid  out  1  result available
- res_ready  in  1  result accepted
- res_index  out  IDX_W  tag of presented result
- res_data  out  ACC_W  signed dot product

## Operation
- Lane states: FREE → MAC → HOLD → FREE.
- FREE→MAC on disp_valid && disp_ready for that lane: latch win, flt, index, last; acc←0, tap←0; busy bit set next cycle.
- MAC: when mult_en=1, acc += sext(win[tap])·sext(flt[tap]), tap++; after tap reaches TAPS−1 (TAPS=F·F·K) enter HOLD. mult_en=0: hold acc/tap.
- HOLD: eligible for output arbiter. Round-robin grant starting one past last granted lane; grant locked while res_valid && !res_ready. On handshake lane → FREE, busy bit clears next cycle, pointer advances.
- last_pending: set on accepting disp_last=1; cleared on drain event.
- Drain event: busy_map becomes all-zero this cycle with no dispatch accepted same cycle. If last_pending → done_full←1, else done_partial pulse.
- done_full cleared by clear or by next accepted dispatch; clear has priority over a same-cycle set: no, set wins (event not lost).
- Arithmetic: two's complement, products 2W, accumulate at ACC_W, wrap (no saturation).
- disp_valid to a busy lane: no effect, request must be held by sender.

## Timing
- Reset: busy_map=0, disp_ready=1, done_partial=0, done_full=0, res_valid=0, res_index=0, res_data=0, all lanes FREE, pointer=0, last_pending=0.
- Dispatch accepted cycle T; with mult_en continuously 1, lane in HOLD and res_valid at T+TAPS+1 (T+28 default) if granted.
- Each cycle of mult_en=0 during MAC adds one cycle.
- res_* combinational from granted HOLD lane; stable while res_valid && !res_ready.
- Freed lane not dispatchable in the handshake cycle; earliest re-accept handshake+1.
- done_partial/done_full asserted cycle after drain handshake.
- rstn low mid-operation: all in-flight work discarded, outputs to reset values asynchronously.

## Structure
- Package conv_pkg: W, F, K, ACC_W, IDX_W, TAPS, lane_state_t enum {L_FREE, L_MAC, L_HOLD}, window/filter packed typedefs.
- Sub-module conv_mac_lane (one per lane: latch, tap counter, single multiplier, accumulator, state). Top holds arbiter, busy_map, done logic.

## Test plan
- Lane 0, win all 1, flt all 2, disp_last=0 → res_data=54, res_index echoed at T+28; done_partial one pulse after handshake.
- Win all −3, flt all 5 → res_data=−405 sign-extended to 56 bits.
- mult_en low 10 cycles mid-MAC → result at T+38, value unchanged.
- Fill all 8 lanes, res_ready=0 → busy_map=0xFF, disp_ready=0 for all; release → results in order 0..7, one per cycle.
- Lanes 0-2 in flight, lane 3 dispatched with disp_last=1 → no done_partial; done_full only after 4th result drains; stays 1 until clear.
- rstn pulse mid-MAC → busy_map=0, res_valid=0 immediately; new dispatch completes correctly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution MAC pool.
// W/ACC_W/IDX_W set the data widths. F*F*K taps make up one dot product.
// Windows and filters are packed vectors: element (k,r,c) sits at
// bits [((k*F+r)*F+c)*W +: W].
package conv_pkg;
    localparam int W     = 24;
    localparam int F     = 3;
    localparam int K     = 3;
    localparam int ACC_W = 56;
    localparam int IDX_W = 24;
    localparam int TAPS  = F * F * K;
    localparam int TAP_W = $clog2(TAPS);
    localparam int VEC_W = TAPS * W;

    typedef enum logic [1:0] {L_FREE, L_MAC, L_HOLD} lane_state_t;

    typedef logic [VEC_W-1:0] win_t;
    typedef logic [VEC_W-1:0] flt_t;
endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: latches a window/filter pair and walks the taps with a
// single multiplier, one tap per enabled cycle. The result is then held
// until the pool's output arbiter pops it.
//   start   : accept a dispatch (only acted on while FREE)
//   win/flt : packed operands; index is the tag echoed with the result
//   mult_en : compute enable, the lane stalls when low
//   pop     : result handshake for this lane
//   busy    : lane is MAC or HOLD; hold: result ready for arbitration
//   acc/idx : accumulated result and its tag
module conv_mac_lane
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  win_t             win,
    input  flt_t             flt,
    input  logic [IDX_W-1:0] index,
    input  logic             mult_en,
    input  logic             pop,
    output logic             busy,
    output logic             hold,
    output logic [ACC_W-1:0] acc,
    output logic [IDX_W-1:0] idx
);
    lane_state_t      state_q, state_d;
    win_t             win_q, win_d;
    flt_t             flt_q, flt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [TAP_W-1:0] tap_q, tap_d;

    logic signed [W-1:0]   a_s, b_s;
    logic signed [2*W-1:0] prod;
    logic [ACC_W-1:0]      prod_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= L_FREE;
            win_q   <= '0;
            flt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            flt_q   <= flt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            L_FREE:  if (start) state_d = L_MAC;
            L_MAC:   if (mult_en && tap_q == TAP_W'(TAPS - 1)) state_d = L_HOLD;
            L_HOLD:  if (pop) state_d = L_FREE;
            default: state_d = L_FREE;
        endcase
    end

    // Sign-extend both operands to 2W before multiplying, then extend the
    // product to the accumulator width; the sum wraps on overflow.
    always_comb begin
        a_s      = win_q[tap_q * W +: W];
        b_s      = flt_q[tap_q * W +: W];
        prod     = (2*W)'(a_s) * (2*W)'(b_s);
        prod_ext = {{(ACC_W - 2*W){prod[2*W-1]}}, prod};
        win_d    = win_q;
        flt_d    = flt_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        tap_d    = tap_q;
        if (state_q == L_FREE && start) begin
            win_d = win;
            flt_d = flt;
            idx_d = index;
            acc_d = '0;
            tap_d = '0;
        end else if (state_q == L_MAC && mult_en) begin
            acc_d = acc_q + prod_ext;
            if (tap_q != TAP_W'(TAPS - 1)) tap_d = tap_q + 1'b1;
        end
    end

    always_comb begin
        busy = (state_q != L_FREE);
        hold = (state_q == L_HOLD);
        acc  = acc_q;
        idx  = idx_q;
    end
endmodule

// File: rtl/conv_mac_pool.sv
// Pool of MAC lanes behind the convolution controller's dispatch port.
// The pool accepts a dispatch into the selected lane when that lane is
// free. A round-robin arbiter streams finished results to writeback.
// busy_map is reported back to the controller, and the pool signals
// when it drains: done_partial is a one-cycle pulse, done_full is sticky
// after a last-tagged dispatch.
//   disp_*   : dispatch request (valid/ready, lane, tag, last, operands)
//   mult_en  : pool-wide compute enable
//   busy_map : per-lane occupancy
//   done_*   : drain indications; clear drops done_full
//   res_*    : result stream (valid/ready, tag, signed dot product)
module conv_mac_pool
    import conv_pkg::*;
#(
    parameter int NLANE     = 8,
    parameter int LANE_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [LANE_BITS-1:0] disp_lane,
    input  logic [IDX_W-1:0]     disp_index,
    input  logic                 disp_last,
    input  win_t                 disp_win,
    input  flt_t                 disp_flt,
    input  logic                 mult_en,
    output logic [NLANE-1:0]     busy_map,
    output logic                 done_partial,
    output logic                 done_full,
    input  logic                 clear,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDX_W-1:0]     res_index,
    output logic [ACC_W-1:0]     res_data
);
    logic [NLANE-1:0]            lane_start, lane_pop, lane_hold;
    logic [NLANE-1:0][ACC_W-1:0] lane_acc;
    logic [NLANE-1:0][IDX_W-1:0] lane_idx;

    logic                 disp_acc, res_hs, drain;
    logic                 gnt_vld;
    logic [LANE_BITS-1:0] gnt_lane, cand;

    logic [LANE_BITS-1:0] ptr_q, ptr_d, lock_lane_q, lock_lane_d;
    logic                 lock_q, lock_d;
    logic                 last_pending_q, last_pending_d;
    logic                 done_partial_q, done_partial_d;
    logic                 done_full_q, done_full_d;

    assign disp_ready = !busy_map[disp_lane];
    assign disp_acc   = disp_valid && disp_ready;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        assign lane_start[i] = disp_acc && (disp_lane == LANE_BITS'(i));
        assign lane_pop[i]   = res_hs && (gnt_lane == LANE_BITS'(i));
        conv_mac_lane u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .start   (lane_start[i]),
            .win     (disp_win),
            .flt     (disp_flt),
            .index   (disp_index),
            .mult_en (mult_en),
            .pop     (lane_pop[i]),
            .busy    (busy_map[i]),
            .hold    (lane_hold[i]),
            .acc     (lane_acc[i]),
            .idx     (lane_idx[i])
        );
    end

    // Round-robin search starts at ptr_q, which is one past the last grant.
    // A stalled result keeps its grant so res_* stay stable until taken.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_lane = lock_lane_q;
        cand     = '0;
        if (lock_q) begin
            gnt_vld = 1'b1;
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                cand = ptr_q + LANE_BITS'(i);
                if (!gnt_vld && lane_hold[cand]) begin
                    gnt_vld  = 1'b1;
                    gnt_lane = cand;
                end
            end
        end
    end

    assign res_valid = gnt_vld;
    assign res_index = gnt_vld ? lane_idx[gnt_lane] : '0;
    assign res_data  = gnt_vld ? lane_acc[gnt_lane] : '0;
    assign res_hs    = res_valid && res_ready;

    // A drain happens when this handshake frees the only busy lane and no
    // new work arrives in the same cycle.
    assign drain = res_hs && ((busy_map & ~lane_pop) == '0) && !disp_acc;

    always_comb begin
        ptr_d          = res_hs ? gnt_lane + 1'b1 : ptr_q;
        lock_d         = res_valid && !res_ready;
        lock_lane_d    = gnt_lane;
        last_pending_d = last_pending_q;
        if (disp_acc && disp_last) last_pending_d = 1'b1;
        if (drain) last_pending_d = 1'b0;
        done_partial_d = drain && !last_pending_q;
        // Setting has priority over clearing so a drain event is never lost.
        done_full_d = done_full_q;
        if (clear || disp_acc) done_full_d = 1'b0;
        if (drain && last_pending_q) done_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q          <= '0;
            lock_q         <= 1'b0;
            lock_lane_q    <= '0;
            last_pending_q <= 1'b0;
            done_partial_q <= 1'b0;
            done_full_q    <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            lock_q         <= lock_d;
            lock_lane_q    <= lock_lane_d;
            last_pending_q <= last_pending_d;
            done_partial_q <= done_partial_d;
            done_full_q    <= done_full_d;
        end
    end

    assign done_partial = done_partial_q;
    assign done_full    = done_full_q;
endmodule
